periph_bus_arbiter: RTL and testbench

//   Round-robin arbiter for the shared peripheral command bus (device/command/data) feeding the
//   LED register and other memory-mapped peripherals. Up to NUM_REQ masters post one transaction

---
 rtl/periph_bus_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/periph_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral command bus: device/command codes and arbiter states.
package periph_bus_pkg;

  localparam int unsigned PB_DEV_W = 5;
  localparam int unsigned PB_CMD_W = 6;

  localparam logic [PB_DEV_W-1:0] DEV_LEDS  = 5'd0;
  localparam logic [PB_DEV_W-1:0] DEV_NONE  = 5'h1F;
  localparam logic [PB_CMD_W-1:0] CMD_NOP   = 6'd0;
  localparam logic [PB_CMD_W-1:0] CMD_WRITE = 6'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above i_last_grant, with wrap.
//   i_req        request vector
//   i_last_grant index of the most recent winner
//   o_grant_c    one-hot winner (zero when nothing requests)
//   o_idx_c      winner index
//   o_valid_c    at least one request is set
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_valid_c
);

  logic [IDX_W-1:0] w_cand;

  // Walk last+1 .. last+NUM_REQ; the first hit wins, later hits are ignored.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(i_last_grant) + k) % NUM_REQ);
      if (!o_valid_c && i_req[w_cand]) begin
        o_valid_c         = 1'b1;
        o_idx_c           = w_cand;
        o_grant_c[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter for the shared peripheral command bus.
//   clk, reset      clock, asynchronous active-low reset
//   req/req_*       per-master request level and flattened device/command/data fields
//   bus_ready       addressed peripheral accepts the current command
//   ack, err        one-cycle one-hot completion pulse, err flags a timeout
//   bus_*           shared bus fields (NOP to DEV_NONE when idle)
//   busy            transfer in flight (ISSUE or DONE)
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEV_W   = 5,
  parameter int unsigned CMD_W   = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DEV_W-1:0]  req_device,
  input  logic [NUM_REQ*CMD_W-1:0]  req_command,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      bus_ready,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic [DEV_W-1:0]          bus_device,
  output logic [CMD_W-1:0]          bus_command,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DEV_W-1:0] BUS_DEV_IDLE = DEV_W'(DEV_NONE);
  localparam logic [CMD_W-1:0] BUS_CMD_IDLE = CMD_W'(CMD_NOP);
  localparam logic [IDX_W-1:0] LAST_RESET   = IDX_W'(NUM_REQ - 1);

  arb_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_win_idx, w_win_idx_nxt;
  logic [NUM_REQ-1:0]  r_win_oh, w_win_oh_nxt;
  logic [IDX_W-1:0]    r_last, w_last_nxt;
  logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
  logic                r_err, w_err_nxt;
  logic                r_busy, w_busy_nxt;
  logic [DEV_W-1:0]    r_dev, w_dev_nxt;
  logic [CMD_W-1:0]    r_cmd, w_cmd_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic                w_valid;
  logic                w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req        (req),
    .i_last_grant (r_last),
    .o_grant_c    (w_grant),
    .o_idx_c      (w_idx),
    .o_valid_c    (w_valid)
  );

  // Wait counter expiry; a zero TIMEOUT disables it entirely.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_win_idx_nxt = r_win_idx;
    w_win_oh_nxt  = r_win_oh;
    w_last_nxt    = r_last;
    w_ack_nxt     = '0;
    w_err_nxt     = 1'b0;
    w_busy_nxt    = r_busy;
    w_dev_nxt     = r_dev;
    w_cmd_nxt     = r_cmd;
    w_data_nxt    = r_data;
    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_valid) begin
          w_state_nxt   = S_ISSUE;
          w_cnt_nxt     = '0;
          w_win_idx_nxt = w_idx;
          w_win_oh_nxt  = w_grant;
          w_busy_nxt    = 1'b1;
          w_dev_nxt     = req_device[32'(w_idx) * DEV_W +: DEV_W];
          w_cmd_nxt     = req_command[32'(w_idx) * CMD_W +: CMD_W];
          w_data_nxt    = req_data[32'(w_idx) * DATA_W +: DATA_W];
        end
      end
      S_ISSUE: begin
        // Ready wins over a coinciding timeout.
        if (bus_ready || w_timeout) begin
          w_state_nxt = S_DONE;
          w_ack_nxt   = r_win_oh;
          w_err_nxt   = !bus_ready;
          w_last_nxt  = r_win_idx;
          w_dev_nxt   = BUS_DEV_IDLE;
          w_cmd_nxt   = BUS_CMD_IDLE;
          w_data_nxt  = '0;
        end else if (TIMEOUT != 0) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_win_idx <= '0;
      r_win_oh  <= '0;
      r_last    <= LAST_RESET;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_dev     <= BUS_DEV_IDLE;
      r_cmd     <= BUS_CMD_IDLE;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_win_idx <= w_win_idx_nxt;
      r_win_oh  <= w_win_oh_nxt;
      r_last    <= w_last_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_dev     <= w_dev_nxt;
      r_cmd     <= w_cmd_nxt;
      r_data    <= w_data_nxt;
    end
  end

  assign ack         = r_ack;
  assign err         = r_err;
  assign busy        = r_busy;
  assign bus_device  = r_dev;
  assign bus_command = r_cmd;
  assign bus_data    = r_data;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized self-checking bench for periph_bus_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;
  import periph_bus_pkg::*;

  localparam int NR = 4;
  localparam int DW = 5;
  localparam int CW = 6;
  localparam int XW = 32;
  localparam int TO = 16;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_device;
  logic [NR*CW-1:0] req_command;
  logic [NR*XW-1:0] req_data;
  logic             bus_ready;
  logic [NR-1:0]    ack;
  logic             err;
  logic [DW-1:0]    bus_device;
  logic [CW-1:0]    bus_command;
  logic [XW-1:0]    bus_data;
  logic             busy;

  periph_bus_arbiter #(
    .NUM_REQ (NR),
    .DEV_W   (DW),
    .CMD_W   (CW),
    .DATA_W  (XW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_device  (req_device),
    .req_command (req_command),
    .req_data    (req_data),
    .bus_ready   (bus_ready),
    .ack         (ack),
    .err         (err),
    .bus_device  (bus_device),
    .bus_command (bus_command),
    .bus_data    (bus_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: pending requests, their fields and the last winner.
  logic [NR-1:0] m_req;
  logic [DW-1:0] m_dev  [NR];
  logic [CW-1:0] m_cmd  [NR];
  logic [XW-1:0] m_data [NR];
  int            last_g;

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Round-robin rule: first pending master strictly after the last winner, wrapping.
  function automatic int pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive();
    req = m_req;
    for (int i = 0; i < NR; i++) begin
      req_device[i*DW +: DW]  = m_dev[i];
      req_command[i*CW +: CW] = m_cmd[i];
      req_data[i*XW +: XW]    = m_data[i];
    end
  endtask

  task automatic new_fields(input int i);
    m_dev[i]  = DW'($urandom_range(0, 30));
    m_cmd[i]  = CW'($urandom_range(1, 63));
    m_data[i] = $urandom;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cmd"},  64'(bus_command), 64'(CMD_NOP));
    chk({tag, "_dev"},  64'(bus_device),  64'(DEV_NONE));
    chk({tag, "_data"}, 64'(bus_data),    64'd0);
    chk({tag, "_ack"},  64'(ack),         64'd0);
    chk({tag, "_err"},  64'(err),         64'd0);
    chk({tag, "_busy"}, 64'(busy),        64'd0);
  endtask

  // One full transfer starting in an IDLE cycle; d = bus_ready low cycles before it rises.
  task automatic run_txn(input int d, output int w);
    int  len;
    bit  e;
    drive();
    w = pick(m_req, last_g);
    bus_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    e   = (TO != 0) && (d >= TO);
    len = e ? TO : d + 1;
    for (int k = 0; k < len; k++) begin
      bus_ready = (k == d);
      chk("issue_dev",  64'(bus_device),  64'(m_dev[w]));
      chk("issue_cmd",  64'(bus_command), 64'(m_cmd[w]));
      chk("issue_data", 64'(bus_data),    64'(m_data[w]));
      chk("issue_busy", 64'(busy),        64'd1);
      chk("issue_ack",  64'(ack),         64'd0);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NR; i++) begin
          if (i != w && m_req[i]) begin
            new_fields(i);
            if ($urandom_range(0, 3) == 0) m_req[i] = 1'b0;
          end
        end
        drive();
      end
      @(posedge clk); #1;
    end
    chk("done_ack",  64'(ack),         64'(1) << w);
    chk("done_err",  64'(err),         64'(e));
    chk("done_cmd",  64'(bus_command), 64'(CMD_NOP));
    chk("done_dev",  64'(bus_device),  64'(DEV_NONE));
    chk("done_busy", 64'(busy),        64'd1);
    m_req[w] = 1'b0;
    drive();
    bus_ready = 1'($urandom_range(0, 1));
    last_g = w;
    @(posedge clk); #1;
    check_idle("post");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    int d;
    int sel;
    n_pass    = 0;
    n_total   = 0;
    last_g    = NR - 1;
    m_req     = '0;
    bus_ready = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < NR; i++) new_fields(i);
    drive();

    // Reset and idle bus with no requests.
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_idle("idle");
    end

    // LED write from master 0, ready immediately.
    m_req      = 4'b0001;
    m_dev[0]   = DEV_LEDS;
    m_cmd[0]   = CMD_WRITE;
    m_data[0]  = 32'h0000_A5A5;
    run_txn(0, w);
    chk("led_winner", 64'(w), 64'd0);

    // Master 2 with ready delayed 5 cycles.
    m_req = 4'b0100;
    new_fields(2);
    run_txn(5, w);
    chk("delay_winner", 64'(w), 64'd2);

    // Master 1 timing out, then master 3 still gets served.
    m_req = 4'b0010;
    new_fields(1);
    run_txn(99, w);
    chk("to_winner", 64'(w), 64'd1);
    m_req = 4'b1000;
    new_fields(3);
    run_txn(0, w);
    chk("after_to_winner", 64'(w), 64'd3);

    // Reset in the middle of ISSUE abandons the transfer.
    m_req = 4'b0100;
    new_fields(2);
    drive();
    @(posedge clk); #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_idle("async_rst");
    m_req = '0;
    drive();
    @(posedge clk); #1;
    check_idle("in_rst");
    reset  = 1'b1;
    last_g = NR - 1;

    // All masters requesting: grants rotate 0,1,2,3,0.
    for (int n = 0; n < 5; n++) begin
      m_req = '1;
      run_txn(0, w);
      chk("rotate", 64'(w), 64'(n % NR));
    end

    // Exact timeout boundary: ready on the last counted cycle still succeeds.
    m_req = 4'b0001;
    new_fields(0);
    run_txn(TO - 1, w);
    m_req = 4'b0001;
    new_fields(0);
    run_txn(TO, w);

    // Randomized traffic with idle gaps, withdrawals and legal field churn.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        m_req = '0;
        drive();
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          check_idle("gap");
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (!m_req[i] && $urandom_range(0, 1) == 1) begin
          m_req[i] = 1'b1;
          new_fields(i);
        end
      end
      if (m_req == '0) begin
        sel = $urandom_range(0, NR - 1);
        m_req[sel] = 1'b1;
        new_fields(sel);
      end
      sel = $urandom_range(0, 9);
      if (sel < 6)       d = $urandom_range(0, 4);
      else if (sel == 6) d = TO - 1;
      else if (sel == 7) d = TO;
      else if (sel == 8) d = $urandom_range(TO + 1, TO + 4);
      else               d = $urandom_range(5, TO - 2);
      run_txn(d, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
